// File: rtl/mem_burst_ctrl.sv
// mem_burst_ctrl: single-port word memory with a small access sequencer.
// In IDLE it performs single-word reads/writes; a burst request walks a
// pointer through consecutive addresses (wrapping at the top of memory),
// doing one read or write beat per cycle, then pulses done.
//
// States:
//   state | meaning
//   IDLE  | accepting single-word accesses and burst launches
//   BURST | one beat per cycle at pointer until remaining is exhausted
//
// Ports:
//   clk          single clock, rising edge
//   rst          synchronous active-high reset (memory contents are kept)
//   readEn       single-word read request (IDLE only)
//   writeEn      single-word write request (IDLE only)
//   mux_sel      selects the write-data source out of data_in
//   address      single-access address / burst base address
//   data_in      NUM_SRC packed write sources, source k at [k*W +: W]
//   burst_start  burst launch request (ignored when burst_len is 0)
//   burst_write  burst direction, 1 write / 0 read
//   burst_len    number of beats
//   dataOut      registered read data, held when dataValid is low
//   dataValid    dataOut carries a new word this cycle
//   busy         a burst is in progress
//   done         one-cycle pulse the cycle after the last beat
module mem_burst_ctrl #(
  parameter int MEMORY_SIZE      = 1024,
  parameter int MEMORY_ADDR_SIZE = 10,
  parameter int MEMORY_DATA_SIZE = 16,
  parameter int NUM_SRC          = 2,
  localparam int SEL_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                readEn,
  input  logic                                writeEn,
  input  logic [SEL_W-1:0]                    mux_sel,
  input  logic [MEMORY_ADDR_SIZE-1:0]         address,
  input  logic [NUM_SRC*MEMORY_DATA_SIZE-1:0] data_in,
  input  logic                                burst_start,
  input  logic                                burst_write,
  input  logic [MEMORY_ADDR_SIZE:0]           burst_len,
  output logic [MEMORY_DATA_SIZE-1:0]         dataOut,
  output logic                                dataValid,
  output logic                                busy,
  output logic                                done
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                        state, state_nxt;
  logic [MEMORY_DATA_SIZE-1:0]   mem [MEMORY_SIZE];
  logic [MEMORY_ADDR_SIZE-1:0]   pointer;
  logic [MEMORY_ADDR_SIZE:0]     remaining;
  logic                          dir;

  logic                          launch;
  logic                          last_beat;
  logic                          mem_we;
  logic                          mem_re;
  logic [MEMORY_ADDR_SIZE-1:0]   acc_addr;
  logic [MEMORY_DATA_SIZE-1:0]   wr_data;

  // Source select; codes with no matching source write zero.
  always_comb begin
    wr_data = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (mux_sel == SEL_W'(k)) wr_data = data_in[k*MEMORY_DATA_SIZE +: MEMORY_DATA_SIZE];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    last_beat = 1'b0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    acc_addr  = address;
    busy      = 1'b0;
    unique case (state)
      IDLE: begin
        // A valid launch swallows any single access presented alongside it.
        if (burst_start && burst_len != '0) begin
          launch    = 1'b1;
          state_nxt = BURST;
        end else begin
          mem_we = writeEn;
          mem_re = readEn;
        end
      end
      BURST: begin
        busy     = 1'b1;
        acc_addr = pointer;
        mem_we   = dir;
        mem_re   = !dir;
        if (remaining == (MEMORY_ADDR_SIZE+1)'(1)) begin
          last_beat = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pointer   <= '0;
      remaining <= '0;
      dir       <= 1'b0;
      dataOut   <= '0;
      dataValid <= 1'b0;
      done      <= 1'b0;
    end else begin
      dataValid <= mem_re;
      done      <= last_beat;
      if (mem_re) dataOut <= mem[acc_addr];
      if (launch) begin
        pointer   <= address;
        remaining <= burst_len;
        dir       <= burst_write;
      end else if (state == BURST) begin
        // Pointer width equals the address width, so it wraps naturally.
        pointer   <= pointer + 1'b1;
        remaining <= remaining - 1'b1;
      end
    end
  end

  // Memory is never cleared; a reset edge suppresses the beat in flight.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[acc_addr] <= wr_data;
  end

endmodule

// File: tb/tb_mem_burst_ctrl.sv
module tb_mem_burst_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        readEn;
  logic        writeEn;
  logic [0:0]  mux_sel;
  logic [9:0]  address;
  logic [31:0] data_in;
  logic        burst_start;
  logic        burst_write;
  logic [10:0] burst_len;
  logic [15:0] dataOut;
  logic        dataValid;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  mem_burst_ctrl dut (
    .clk(clk), .rst(rst), .readEn(readEn), .writeEn(writeEn),
    .mux_sel(mux_sel), .address(address), .data_in(data_in),
    .burst_start(burst_start), .burst_write(burst_write), .burst_len(burst_len),
    .dataOut(dataOut), .dataValid(dataValid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; readEn = 1'b0; writeEn = 1'b0; mux_sel = 1'b0; address = '0;
    data_in = '0; burst_start = 1'b0; burst_write = 1'b0; burst_len = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_dataOut", 32'(dataOut), 32'h0);
    chk("rst_dataValid", 32'(dataValid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);

    // single writes from each source
    writeEn = 1'b1; mux_sel = 1'b0; address = 10'h005; data_in = {16'h0000, 16'h1234};
    tick();
    mux_sel = 1'b1; address = 10'h006; data_in = {16'hBEEF, 16'h0000};
    tick();
    writeEn = 1'b0; readEn = 1'b1; address = 10'h005;
    tick();
    chk("rd5_valid", 32'(dataValid), 32'h1);
    chk("rd5_data", 32'(dataOut), 32'h1234);
    address = 10'h006;
    tick();
    chk("rd6_valid", 32'(dataValid), 32'h1);
    chk("rd6_data", 32'(dataOut), 32'hBEEF);
    readEn = 1'b0;
    tick();
    chk("hold_valid", 32'(dataValid), 32'h0);
    chk("hold_data", 32'(dataOut), 32'hBEEF);

    // write burst across the top-of-memory wrap
    mux_sel = 1'b0; address = 10'h3FE; burst_start = 1'b1; burst_write = 1'b1; burst_len = 11'd4;
    tick();
    burst_start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      data_in = {16'h0000, 16'(i)};
      chk($sformatf("wb_busy%0d", i), 32'(busy), 32'h1);
      chk($sformatf("wb_done%0d", i), 32'(done), 32'h0);
      tick();
    end
    chk("wb_busy_end", 32'(busy), 32'h0);
    chk("wb_done_pulse", 32'(done), 32'h1);
    tick();
    chk("wb_done_clear", 32'(done), 32'h0);

    // read burst back; request a single read in the done cycle
    address = 10'h3FE; burst_start = 1'b1; burst_write = 1'b0; burst_len = 11'd4;
    tick();
    burst_start = 1'b0;
    chk("rb_busy", 32'(busy), 32'h1);
    chk("rb_valid0", 32'(dataValid), 32'h0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("rb_valid%0d", i), 32'(dataValid), 32'h1);
      chk($sformatf("rb_data%0d", i), 32'(dataOut), 32'(i));
      chk($sformatf("rb_done%0d", i), 32'(done), (i == 4) ? 32'h1 : 32'h0);
    end
    readEn = 1'b1; address = 10'h005;
    tick();
    readEn = 1'b0;
    chk("b2b_valid", 32'(dataValid), 32'h1);
    chk("b2b_data", 32'(dataOut), 32'h1234);
    chk("b2b_done", 32'(done), 32'h0);

    // zero-length burst is ignored, read goes ahead
    burst_start = 1'b1; burst_len = 11'd0; burst_write = 1'b1; readEn = 1'b1; address = 10'h005;
    tick();
    burst_start = 1'b0; readEn = 1'b0;
    chk("z_busy", 32'(busy), 32'h0);
    chk("z_done", 32'(done), 32'h0);
    chk("z_valid", 32'(dataValid), 32'h1);
    chk("z_data", 32'(dataOut), 32'h1234);
    tick();
    chk("z_done_after", 32'(done), 32'h0);

    // reset mid-burst: preload 0x102..0x107 with known values
    writeEn = 1'b1; mux_sel = 1'b0;
    for (int i = 2; i < 8; i++) begin
      address = 10'h100 + 10'(i); data_in = {16'h0000, 16'h0C00 + 16'(i)};
      tick();
    end
    writeEn = 1'b0;
    address = 10'h100; burst_start = 1'b1; burst_write = 1'b1; burst_len = 11'd8;
    data_in = {16'h0000, 16'hAAAA};
    tick();
    burst_start = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("ab_dataOut", 32'(dataOut), 32'h0);
    chk("ab_valid", 32'(dataValid), 32'h0);
    chk("ab_busy", 32'(busy), 32'h0);
    chk("ab_done", 32'(done), 32'h0);
    tick();
    chk("ab_busy2", 32'(busy), 32'h0);
    chk("ab_done2", 32'(done), 32'h0);
    readEn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      address = 10'h100 + 10'(i);
      tick();
      chk($sformatf("ab_mem%0d", i), 32'(dataOut), (i < 2) ? 32'hAAAA : 32'h0C00 + 32'(i));
    end
    readEn = 1'b0;

    // same-cycle read and write returns the old word
    readEn = 1'b1; writeEn = 1'b1; address = 10'h005; mux_sel = 1'b0; data_in = {16'h0000, 16'h5555};
    tick();
    writeEn = 1'b0;
    chk("rw_old", 32'(dataOut), 32'h1234);
    tick();
    readEn = 1'b0;
    chk("rw_new", 32'(dataOut), 32'h5555);
    chk("rw_valid", 32'(dataValid), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
